presorter_ctrl: RTL and testbench



---
 rtl/presorter_ctrl_pkg.sv | 13 +
 rtl/presorter_ctrl_presorter.sv | 57 +++++
 rtl/presorter_ctrl.sv | 136 +++++++++++++
 tb/tb_presorter_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/presorter_ctrl_pkg.sv
// Shared constants and FSM state type for the presorter flow-control wrapper.
// The presorter stage count lives here so the wrapper and the pipeline agree.
package presorter_ctrl_pkg;

    localparam int LATENCY      = 10;
    localparam int BEAT_RECORDS = 16;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/presorter_ctrl_presorter.sv
// Free-running 16-record bitonic sorting network, one register per compare stage.
// No valid, no stall, no reset on data; record 0 of the output is the smallest.
module presorter
    import presorter_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                               clk_i,
    input  logic [BEAT_RECORDS*DATA_WIDTH-1:0] in_data_i,
    output logic [BEAT_RECORDS*DATA_WIDTH-1:0] out_data_o
);

    localparam int N = BEAT_RECORDS;

    logic [DATA_WIDTH-1:0] pipe_in [N];
    logic [DATA_WIDTH-1:0] pipe_q  [LATENCY][N];

    for (genvar r = 0; r < N; r++) begin : g_io
        assign pipe_in[r]                      = in_data_i[r*DATA_WIDTH +: DATA_WIDTH];
        assign out_data_o[r*DATA_WIDTH +: DATA_WIDTH] = pipe_q[LATENCY-1][r];
    end

    // Pass p merges bitonic runs of size 2^p; it takes p steps, 1+2+3+4 = 10 stages.
    for (genvar p = 1; p <= 4; p++) begin : g_pass
        for (genvar q = 0; q < p; q++) begin : g_step
            localparam int S = (p * (p - 1)) / 2 + q;
            localparam int J = 1 << (p - 1 - q);
            localparam int K = 1 << p;

            logic [DATA_WIDTH-1:0] src [N];
            logic [DATA_WIDTH-1:0] dst [N];

            if (S == 0) begin : g_first
                assign src = pipe_in;
            end else begin : g_next
                assign src = pipe_q[S-1];
            end

            for (genvar i = 0; i < N; i++) begin : g_cell
                localparam int  L        = i ^ J;
                localparam bit  KEEP_MIN = (((i & K) == 0) == ((i & J) == 0));
                logic a_lt_b;
                assign a_lt_b = src[i] < src[L];
                if (KEEP_MIN) begin : g_min
                    assign dst[i] = a_lt_b ? src[i] : src[L];
                end else begin : g_max
                    assign dst[i] = a_lt_b ? src[L] : src[i];
                end
            end

            always_ff @(posedge clk_i) begin
                pipe_q[S] <= dst;
            end
        end
    end

endmodule

// File: rtl/presorter_ctrl.sv
// Credit-based flow-control wrapper around the unstallable presorter pipeline.
// Optional statistics counters are built when PRESORT_CTRL_STATS_EN is defined.
module presorter_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = presorter_ctrl_pkg::LATENCY,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                                  aclk,
    input  logic                                                  areset,
    input  logic [presorter_ctrl_pkg::BEAT_RECORDS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                                                  s_axis_tvalid,
    input  logic                                                  s_axis_tlast,
    output logic                                                  s_axis_tready,
    output logic [presorter_ctrl_pkg::BEAT_RECORDS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                                                  m_axis_tvalid,
    output logic                                                  m_axis_tlast,
    input  logic                                                  m_axis_tready,
    output logic                                                  frame_done
`ifdef PRESORT_CTRL_STATS_EN
    ,
    output logic [31:0]                                           stat_beats,
    output logic [31:0]                                           stat_frames,
    output logic [31:0]                                           stat_stall
`endif
);

    import presorter_ctrl_pkg::*;

    localparam int BW = BEAT_RECORDS * DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    state_t              state_q, state_d;
    logic [LATENCY-1:0]  valid_sr_q, last_sr_q;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [BW-1:0]       mem_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q;
    logic [BW-1:0]       sorted;
    logic [CW:0]         committed;
    logic                accept, push, pop, credit_ok, drain_done;

    presorter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_presorter (
        .clk_i      (aclk),
        .in_data_i  (s_axis_tdata),
        .out_data_o (sorted)
    );

    // Every beat already in flight or buffered owns a FIFO slot, so the tail write can never be refused.
    assign committed  = {1'b0, count_q} + {1'b0, inflight_q};
    assign credit_ok  = committed < (CW+1)'(FIFO_DEPTH);
    assign drain_done = (inflight_q == '0) && (count_q == '0);

    assign accept = s_axis_tvalid && s_axis_tready;
    assign push   = valid_sr_q[LATENCY-1];
    assign pop    = m_axis_tvalid && m_axis_tready;

    assign inflight_d = inflight_q + CW'(accept) - CW'(push);
    assign count_d    = count_q + CW'(push) - CW'(pop);

    assign m_axis_tvalid = !areset && (count_q != '0);
    assign m_axis_tdata  = mem_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && mem_last_q[rd_ptr_q];

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && s_axis_tlast) state_d = DRAIN;
            DRAIN:   if (drain_done)             state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // drain_done uses registered counts, so the final pop has already retired when it is seen.
    always_comb begin
        s_axis_tready = !areset && (state_q == RUN) && credit_ok;
        frame_done    = !areset && (state_q == DRAIN) && drain_done;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_sr_q <= '0;
            last_sr_q  <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            valid_sr_q <= {valid_sr_q[LATENCY-2:0], accept};
            last_sr_q  <= {last_sr_q[LATENCY-2:0], accept && s_axis_tlast};
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= sorted;
            mem_last_q[wr_ptr_q] <= last_sr_q[LATENCY-1];
        end
    end

`ifdef PRESORT_CTRL_STATS_EN
    logic [31:0] stat_beats_q, stat_frames_q, stat_stall_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            stat_beats_q  <= '0;
            stat_frames_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (accept && (stat_beats_q != '1))                    stat_beats_q  <= stat_beats_q + 32'd1;
            if (frame_done && (stat_frames_q != '1))               stat_frames_q <= stat_frames_q + 32'd1;
            if (s_axis_tvalid && !s_axis_tready && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_beats  = stat_beats_q;
    assign stat_frames = stat_frames_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_presorter_ctrl.sv
// Directed bench for presorter_ctrl: latency, streaming, backpressure, random stall,
// mid-frame reset, and the PRESORT_CTRL_STATS_EN counters when that macro is defined.
module tb_presorter_ctrl;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int BW = NR * DW;

  logic          aclk = 1'b0;
  logic          areset;
  logic [BW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [BW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          frame_done;
`ifdef PRESORT_CTRL_STATS_EN
  logic [31:0]   stat_beats, stat_frames, stat_stall;
`endif

  presorter_ctrl dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .frame_done    (frame_done)
`ifdef PRESORT_CTRL_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_frames   (stat_frames),
    .stat_stall    (stat_stall)
`endif
  );

  // clock / reset
  always #5 aclk = ~aclk;

  // scoreboard state
  logic [BW:0]   exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_out    = 0;
  int            fd_count = 0;
  int            stall_cnt = 0;
  int            beat_idx = 0;
  bit            rand_ready = 0;
  logic [BW-1:0] cur_beat;
  logic          prev_stall = 1'b0;
  logic [BW:0]   prev_beat;

  task automatic check(input string tag, input logic [BW:0] obs, input logic [BW:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] v;
    for (int r = 0; r < NR; r++) v[r*DW +: DW] = $urandom();
    return v;
  endfunction

  function automatic logic [BW-1:0] sort_beat(input logic [BW-1:0] v);
    logic [DW-1:0] a [NR];
    logic [DW-1:0] t;
    logic [BW-1:0] o;
    for (int r = 0; r < NR; r++) a[r] = v[r*DW +: DW];
    for (int i = 1; i < NR; i++) begin
      for (int j = i; j > 0; j--) begin
        if (a[j] < a[j-1]) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
      end
    end
    for (int r = 0; r < NR; r++) o[r*DW +: DW] = a[r];
    return o;
  endfunction

  // output monitor: ordering, content and stability under stall
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done) fd_count++;
      if (prev_stall) begin
        check("stall_tvalid_held", m_axis_tvalid, 1'b1);
        check("stall_beat_stable", {m_axis_tlast, m_axis_tdata}, prev_beat);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_beat", exp_q.size(), 1);
        else check("out_beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
    end
  end

  // driver: present beats of an nbeats frame for up to ncyc cycles; starts/ends at posedge+1
  task automatic drive_cycles(input int ncyc, input int nbeats);
    for (int c = 0; c < ncyc && beat_idx < nbeats; c++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = cur_beat;
      s_axis_tlast  = (beat_idx == nbeats - 1);
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      @(negedge aclk);
      if (s_axis_tready) begin
        exp_q.push_back({s_axis_tlast, sort_beat(cur_beat)});
        beat_idx++;
        cur_beat = rand_beat();
      end else begin
        stall_cnt++;
      end
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int bound);
    for (int c = 0; c < bound && fd_count < target; c++) begin
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      @(posedge aclk); #1;
    end
    check("frame_done_count", fd_count, target);
  endtask

  logic [BW-1:0] in_desc, out_asc;
  int            base_out, base_stall, base_fd;

  initial begin
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    cur_beat      = rand_beat();

    // reset values
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("reset_s_tready", s_axis_tready, 1'b0);
    check("reset_m_tvalid", m_axis_tvalid, 1'b0);
    check("reset_m_tlast", m_axis_tlast, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    @(posedge aclk); #1;
    areset        = 1'b0;
    m_axis_tready = 1'b1;

    // single descending beat, tlast: latency and frame_done timing
    for (int r = 0; r < NR; r++) begin
      in_desc[r*DW +: DW] = 32'(15 - r);
      out_asc[r*DW +: DW] = 32'(r);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = in_desc;
    s_axis_tlast  = 1'b1;
    @(negedge aclk);
    check("first_accept", s_axis_tready, 1'b1);
    exp_q.push_back({1'b1, out_asc});
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      check("latency_not_yet", m_axis_tvalid, 1'b0);
      check("drain_tready_low", s_axis_tready, 1'b0);
    end
    @(negedge aclk);
    check("latency_tvalid", m_axis_tvalid, 1'b1);
    check("single_tdata", m_axis_tdata, out_asc);
    check("single_tlast", m_axis_tlast, 1'b1);
    check("no_early_done", frame_done, 1'b0);
    @(negedge aclk);
    check("frame_done_pulse", frame_done, 1'b1);
    check("fifo_empty_after_pop", m_axis_tvalid, 1'b0);
    check("tready_low_at_done", s_axis_tready, 1'b0);
    @(negedge aclk);
    check("frame_done_one_cycle", frame_done, 1'b0);
    check("tready_back", s_axis_tready, 1'b1);
    @(posedge aclk); #1;

    // 64-beat stream, ready held high: one beat per cycle
    base_out   = n_out;
    base_stall = stall_cnt;
    base_fd    = fd_count;
    beat_idx   = 0;
    drive_cycles(100, 64);
    check("stream_accepted", beat_idx, 64);
    check("stream_no_stall", stall_cnt - base_stall, 0);
    wait_frames(base_fd + 1, 200);
    check("stream_out_count", n_out - base_out, 64);
    check("stream_queue_empty", exp_q.size(), 0);

    // backpressure: 40 cycles with downstream stalled admits exactly FIFO_DEPTH beats
    m_axis_tready = 1'b0;
    base_out = n_out;
    base_fd  = fd_count;
    beat_idx = 0;
    drive_cycles(40, 40);
    check("bp_admitted", beat_idx, 16);
    @(negedge aclk);
    check("bp_tready_low", s_axis_tready, 1'b0);
    check("bp_tvalid_held", m_axis_tvalid, 1'b1);
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    drive_cycles(500, 40);
    check("bp_all_accepted", beat_idx, 40);
    wait_frames(base_fd + 1, 200);
    check("bp_out_count", n_out - base_out, 40);

    // 200 beats in 5 frames with 50% downstream ready
    rand_ready = 1;
    base_out   = n_out;
    base_fd    = fd_count;
    for (int f = 0; f < 5; f++) begin
      beat_idx = 0;
      drive_cycles(2000, 40);
      check("rand_frame_accepted", beat_idx, 40);
      wait_frames(base_fd + f + 1, 2000);
    end
    rand_ready    = 0;
    m_axis_tready = 1'b1;
    check("rand_out_count", n_out - base_out, 200);
    check("rand_queue_empty", exp_q.size(), 0);

    // mid-frame reset with 6 beats in flight and 3 buffered
    m_axis_tready = 1'b0;
    beat_idx      = 0;
    drive_cycles(9, 1000);
    check("pre_reset_accepted", beat_idx, 9);
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    check("pre_reset_buffered", m_axis_tvalid, 1'b1);
    areset = 1'b1;
    exp_q.delete();
    @(negedge aclk);
    check("post_reset_tvalid", m_axis_tvalid, 1'b0);
    check("reset_tready_low", s_axis_tready, 1'b0);
    check("post_reset_done", frame_done, 1'b0);
    @(posedge aclk); #1;
    areset        = 1'b0;
    m_axis_tready = 1'b1;
    base_out = n_out;
    base_fd  = fd_count;
    beat_idx = 0;
    drive_cycles(20, 1);
    wait_frames(base_fd + 1, 100);
    check("post_reset_one_beat", n_out - base_out, 1);
    check("post_reset_queue_empty", exp_q.size(), 0);

`ifdef PRESORT_CTRL_STATS_EN
    // statistics: 10 beats in 2 frames, downstream stalled for the first 20 cycles
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset        = 1'b0;
    m_axis_tready = 1'b0;
    base_stall    = stall_cnt;
    base_fd       = fd_count;
    beat_idx = 0;
    drive_cycles(10, 5);
    beat_idx = 0;
    drive_cycles(10, 5);
    m_axis_tready = 1'b1;
    drive_cycles(200, 5);
    wait_frames(base_fd + 2, 200);
    @(negedge aclk);
    check("stat_beats", stat_beats, 32'd10);
    check("stat_frames", stat_frames, 32'd2);
    check("stat_stall", stat_stall, 32'(stall_cnt - base_stall));
    @(posedge aclk); #1;
`endif

    repeat (3) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
